mem_req_arbiter: RTL and testbench
==================================

// Module: mem_req_arbiter
// PURPOSE
//  Sits directly downstream of the multicycle MIPS core. Merges the core's instruction-fetch channel
//  and data load/store channel onto one shared valid/ready memory port, one transaction in flight.
//  Routes read responses back to the requesting channel and counts grants and wait cycles.
// PARAMETERS
//  DATA_PRIO   1   1: data wins simultaneous requests; 0: strict alternation (last-granted loses)
//  CNT_W       32  width of performance counters (wrap-around, no saturation)
// PORTS
//  clk              in   1   single clock, all logic on posedge
//  rst              in   1   reset; synchronous, active-low (0 = reset)
//  i_addr           in   32  fetch address (core PC)
//  i_req_valid      in   1   fetch request valid
//  i_req_ready      out  1   fetch request accepted this cycle
//  i_rdata          out  32  instruction word to core
//  i_rdata_valid    out  1   instruction word valid
//  i_rdata_ready    in   1   core ready for instruction word
//  d_addr           in   32  data address, word-aligned
//  d_wen            in   1   store request
//  d_ren            in   1   load request
//  d_wdata          in   32  store data
//  d_wstrb          in   4   store byte strobes
//  d_req_ready      out  1   data request accepted this cycle
//  d_rdata          out  32  load data to core
//  d_rdata_valid    out  1   load data valid
//  d_rdata_ready    in   1   core ready for load data
//  m_addr/m_wdata   out  32  shared-port address / write data (registered)
//  m_wstrb          out  4   shared-port strobes (registered)
//  m_wen, m_ren     out  1   shared-port write / read command (registered)
//  m_req_ready      in   1   memory accepts command
//  m_rdata          in   32  memory read data
//  m_rdata_valid    in   1   memory read data valid
//  m_rdata_ready    out  1   arbiter ready for read data
//  cnt_i, cnt_d     out  CNT_W  fetch grants / data grants
//  cnt_wait         out  CNT_W  cycles with a valid upstream request not accepted
// BEHAVIOUR
//  Reset: one clock; reset is synchronous and active-low. On rst=0 at posedge: state<=IDLE,
//   m_wen=m_ren=0, m_addr/m_wdata/m_wstrb<=0, all counters<=0, alternation pointer<=inst. Mid-transaction
//   reset abandons the transaction; outstanding command is dropped.
//  States: IDLE -> CMD -> (RESP | IDLE). One-hot encoding, 3 states.
//  IDLE: data request = d_ren|d_wen. Grant per DATA_PRIO/alternation; the granted *_req_ready=1
//   combinationally in that cycle, others 0. At the grant edge capture addr/wdata/wstrb/cmd and owner
//   (I or D), bump cnt_i or cnt_d, go CMD. No request: stay. m_rdata_ready=1 in IDLE (stray beats dropped).
//  d_ren&d_wen both 1: illegal; treated as store (m_wen=1, m_ren=0).
//  Fetch is always a read: m_ren=1, m_wstrb=0.
//  CMD: m_ren/m_wen held from registers (first asserted cycle after grant = 1-cycle latency).
//   Held stable until m_req_ready=1. On accept: read -> RESP; write -> IDLE (no response expected).
//  RESP: m_rdata_ready = owner's *_rdata_ready; owner's *_rdata_valid = m_rdata_valid;
//   *_rdata = m_rdata (combinational pass-through, zero latency); non-owner valid=0.
//   Beat completes when m_rdata_valid & m_rdata_ready -> IDLE. A new grant takes effect only in the
//   following IDLE cycle (minimum 3 cycles per read, 2 per write back-to-back).
//  *_req_ready is 0 outside IDLE; requests held by core until accepted.
//  cnt_wait +1 each cycle (i_req_valid | d_ren | d_wen) and no *_req_ready; all counters wrap 2^CNT_W-1->0.
//  Alternation (DATA_PRIO=0): on simultaneous requests grant the channel not granted last.
// TESTING
//  1 Reset: hold rst=0 3 cycles with i_req_valid=1 -> no ready, m_ren=m_wen=0, cnt_*=0.
//  2 Fetch 0x00000010, memory ready immediately, rdata 0x24020005 after 2 cycles -> i_rdata_valid 1 cycle,
//    i_rdata=0x24020005, cnt_i=1.
//  3 Simultaneous fetch 0x40 and store 0x100 data 0xDEADBEEF strb 0xF, DATA_PRIO=1 -> store issued first
//    (m_wen, m_wdata=0xDEADBEEF), fetch next; cnt_d=1, cnt_i=1, cnt_wait>=2.
//  4 d_ren&d_wen both 1 at 0x8 -> m_wen=1, m_ren=0, no response phase, return to IDLE.
//  5 m_req_ready low 5 cycles in CMD -> m_addr/m_ren stable 6 cycles; d_rdata_ready low 3 cycles in RESP
//    -> m_rdata_ready low, data held, completes on first ready.
//  6 Assert rst=0 in RESP -> IDLE next cycle; subsequent stray m_rdata_valid beat dropped, no *_rdata_valid.

Source files
------------

// File: rtl/mem_req_arbiter_if.sv
// Bundle of the core fetch channel, core data channel and shared memory port.
// master = arbiter view; slave = core plus memory environment view.
interface mem_req_arbiter_if;
  logic [31:0] i_addr;
  logic        i_req_valid;
  logic        i_req_ready;
  logic [31:0] i_rdata;
  logic        i_rdata_valid;
  logic        i_rdata_ready;

  logic [31:0] d_addr;
  logic        d_wen;
  logic        d_ren;
  logic [31:0] d_wdata;
  logic [3:0]  d_wstrb;
  logic        d_req_ready;
  logic [31:0] d_rdata;
  logic        d_rdata_valid;
  logic        d_rdata_ready;

  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [3:0]  m_wstrb;
  logic        m_wen;
  logic        m_ren;
  logic        m_req_ready;
  logic [31:0] m_rdata;
  logic        m_rdata_valid;
  logic        m_rdata_ready;

  modport master (
    input  i_addr, i_req_valid, i_rdata_ready,
    input  d_addr, d_wen, d_ren, d_wdata, d_wstrb, d_rdata_ready,
    input  m_req_ready, m_rdata, m_rdata_valid,
    output i_req_ready, i_rdata, i_rdata_valid,
    output d_req_ready, d_rdata, d_rdata_valid,
    output m_addr, m_wdata, m_wstrb, m_wen, m_ren, m_rdata_ready
  );

  modport slave (
    output i_addr, i_req_valid, i_rdata_ready,
    output d_addr, d_wen, d_ren, d_wdata, d_wstrb, d_rdata_ready,
    output m_req_ready, m_rdata, m_rdata_valid,
    input  i_req_ready, i_rdata, i_rdata_valid,
    input  d_req_ready, d_rdata, d_rdata_valid,
    input  m_addr, m_wdata, m_wstrb, m_wen, m_ren, m_rdata_ready
  );
endinterface

// File: rtl/mem_req_arbiter.sv
// Merges the MIPS core fetch and load/store channels onto one shared memory port,
// one transaction in flight, with grant and wait-cycle performance counters.
module mem_req_arbiter #(
  parameter int unsigned DATA_PRIO = 1,
  parameter int unsigned CNT_W     = 32
) (
  input  logic             clk,
  input  logic             rst,
  mem_req_arbiter_if.master bus,
  output logic [CNT_W-1:0] cnt_i,
  output logic [CNT_W-1:0] cnt_d,
  output logic [CNT_W-1:0] cnt_wait
);
  localparam logic [2:0] IDLE = 3'b001;
  localparam logic [2:0] CMD  = 3'b010;
  localparam logic [2:0] RESP = 3'b100;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [2:0] state;
  logic       owner_d;
  logic       last_d;
  logic       d_req;
  logic       idle;
  logic       resp;
  logic       grant_i;
  logic       grant_d;
  logic       d_store;

  assign d_req   = bus.d_ren | bus.d_wen;
  assign d_store = bus.d_wen;
  assign idle    = (state == IDLE);
  assign resp    = (state == RESP);

  // Readies are suppressed while reset is asserted so nothing is accepted then.
  always_comb begin
    grant_i = 1'b0;
    grant_d = 1'b0;
    if (rst && idle) begin
      if (d_req && ((DATA_PRIO != 0) || !bus.i_req_valid || !last_d))
        grant_d = 1'b1;
      else if (bus.i_req_valid)
        grant_i = 1'b1;
    end
  end

  assign bus.i_req_ready = grant_i;
  assign bus.d_req_ready = grant_d;

  always_comb begin
    bus.m_rdata_ready = 1'b0;
    if (idle)
      bus.m_rdata_ready = 1'b1;
    else if (resp)
      bus.m_rdata_ready = owner_d ? bus.d_rdata_ready : bus.i_rdata_ready;
  end

  assign bus.i_rdata       = bus.m_rdata;
  assign bus.d_rdata       = bus.m_rdata;
  assign bus.i_rdata_valid = resp & ~owner_d & bus.m_rdata_valid;
  assign bus.d_rdata_valid = resp &  owner_d & bus.m_rdata_valid;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      owner_d     <= 1'b0;
      last_d      <= 1'b0;
      bus.m_addr  <= '0;
      bus.m_wdata <= '0;
      bus.m_wstrb <= '0;
      bus.m_wen   <= 1'b0;
      bus.m_ren   <= 1'b0;
      cnt_i       <= '0;
      cnt_d       <= '0;
      cnt_wait    <= '0;
    end else begin
      if ((bus.i_req_valid || d_req) && !(grant_i || grant_d))
        cnt_wait <= cnt_wait + CNT_ONE;
      unique case (state)
        IDLE: begin
          if (grant_d) begin
            // A request with both d_ren and d_wen set is issued as a store.
            bus.m_addr  <= bus.d_addr;
            bus.m_wdata <= bus.d_wdata;
            bus.m_wstrb <= d_store ? bus.d_wstrb : 4'h0;
            bus.m_wen   <= d_store;
            bus.m_ren   <= ~d_store;
            owner_d     <= 1'b1;
            last_d      <= 1'b1;
            cnt_d       <= cnt_d + CNT_ONE;
            state       <= CMD;
          end else if (grant_i) begin
            bus.m_addr  <= bus.i_addr;
            bus.m_wdata <= '0;
            bus.m_wstrb <= 4'h0;
            bus.m_wen   <= 1'b0;
            bus.m_ren   <= 1'b1;
            owner_d     <= 1'b0;
            last_d      <= 1'b0;
            cnt_i       <= cnt_i + CNT_ONE;
            state       <= CMD;
          end
        end
        CMD: begin
          if (bus.m_req_ready) begin
            bus.m_wen <= 1'b0;
            bus.m_ren <= 1'b0;
            state     <= bus.m_ren ? RESP : IDLE;
          end
        end
        RESP: begin
          if (bus.m_rdata_valid && bus.m_rdata_ready)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_req_arbiter.sv
// Directed bench for mem_req_arbiter: reset, fetch, priority, illegal command, stalls, mid-read reset.
module tb_mem_req_arbiter;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] cnt_i, cnt_d, cnt_wait;
  int          total = 0;
  int          bad = 0;

  mem_req_arbiter_if bus();

  mem_req_arbiter #(.DATA_PRIO(1), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .cnt_i(cnt_i), .cnt_d(cnt_d), .cnt_wait(cnt_wait)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    bus.i_addr = '0; bus.i_req_valid = 0; bus.i_rdata_ready = 1;
    bus.d_addr = '0; bus.d_wen = 0; bus.d_ren = 0; bus.d_wdata = '0; bus.d_wstrb = '0;
    bus.d_rdata_ready = 1;
    bus.m_req_ready = 0; bus.m_rdata = '0; bus.m_rdata_valid = 0;

    // Reset held 3 cycles with a pending fetch
    bus.i_req_valid = 1; bus.i_addr = 32'h4;
    for (int k = 0; k < 3; k++) begin
      tick(); #1;
      chk("rst_i_ready", {31'b0, bus.i_req_ready}, 0);
      chk("rst_m_ren", {31'b0, bus.m_ren}, 0);
      chk("rst_m_wen", {31'b0, bus.m_wen}, 0);
      chk("rst_cnt_i", cnt_i, 0);
      chk("rst_cnt_wait", cnt_wait, 0);
    end
    bus.i_req_valid = 0;
    tick(); rst = 1;

    // Fetch 0x10, memory ready immediately, data two cycles into RESP
    bus.i_addr = 32'h10; bus.i_req_valid = 1; bus.m_req_ready = 1; #1;
    chk("f_i_ready", {31'b0, bus.i_req_ready}, 1);
    chk("f_d_ready", {31'b0, bus.d_req_ready}, 0);
    tick(); bus.i_req_valid = 0; #1;
    chk("f_m_ren", {31'b0, bus.m_ren}, 1);
    chk("f_m_addr", bus.m_addr, 32'h10);
    chk("f_m_wstrb", {28'b0, bus.m_wstrb}, 0);
    chk("f_cnt_i", cnt_i, 1);
    chk("f_cmd_ready", {31'b0, bus.i_req_ready}, 0);
    tick(); #1;
    chk("f_resp_ren", {31'b0, bus.m_ren}, 0);
    chk("f_resp_novalid", {31'b0, bus.i_rdata_valid}, 0);
    tick(); bus.m_rdata = 32'h24020005; bus.m_rdata_valid = 1; #1;
    chk("f_rvalid", {31'b0, bus.i_rdata_valid}, 1);
    chk("f_rdata", bus.i_rdata, 32'h24020005);
    chk("f_d_rvalid", {31'b0, bus.d_rdata_valid}, 0);
    tick(); bus.m_rdata_valid = 0; #1;
    chk("f_idle_rvalid", {31'b0, bus.i_rdata_valid}, 0);
    chk("f_cnt_i_end", cnt_i, 1);
    chk("f_cnt_d_end", cnt_d, 0);
    chk("f_cnt_wait", cnt_wait, 0);

    // Simultaneous fetch 0x40 and store 0x100: data priority
    bus.i_addr = 32'h40; bus.i_req_valid = 1;
    bus.d_addr = 32'h100; bus.d_wen = 1; bus.d_wdata = 32'hDEADBEEF; bus.d_wstrb = 4'hF; #1;
    chk("s_d_ready", {31'b0, bus.d_req_ready}, 1);
    chk("s_i_ready", {31'b0, bus.i_req_ready}, 0);
    tick(); bus.d_wen = 0; bus.m_req_ready = 0; #1;
    chk("s_m_wen", {31'b0, bus.m_wen}, 1);
    chk("s_m_ren", {31'b0, bus.m_ren}, 0);
    chk("s_m_wdata", bus.m_wdata, 32'hDEADBEEF);
    chk("s_m_addr", bus.m_addr, 32'h100);
    chk("s_m_wstrb", {28'b0, bus.m_wstrb}, 32'hF);
    tick(); bus.m_req_ready = 1; #1;
    chk("s_hold_wen", {31'b0, bus.m_wen}, 1);
    tick(); #1;
    chk("s2_i_ready", {31'b0, bus.i_req_ready}, 1);
    chk("s2_m_wen_clr", {31'b0, bus.m_wen}, 0);
    tick(); bus.i_req_valid = 0; #1;
    chk("s2_m_ren", {31'b0, bus.m_ren}, 1);
    chk("s2_m_addr", bus.m_addr, 32'h40);
    tick(); bus.m_rdata = 32'h8C420000; bus.m_rdata_valid = 1; #1;
    chk("s2_rvalid", {31'b0, bus.i_rdata_valid}, 1);
    chk("s2_rdata", bus.i_rdata, 32'h8C420000);
    tick(); bus.m_rdata_valid = 0; #1;
    chk("s_cnt_i", cnt_i, 2);
    chk("s_cnt_d", cnt_d, 1);
    chk("s_cnt_wait", cnt_wait, 2);

    // Illegal d_ren & d_wen: issued as store, no response phase
    bus.d_addr = 32'h8; bus.d_ren = 1; bus.d_wen = 1; bus.d_wdata = 32'h11223344; bus.d_wstrb = 4'h3; #1;
    chk("x_d_ready", {31'b0, bus.d_req_ready}, 1);
    tick(); bus.d_ren = 0; bus.d_wen = 0; #1;
    chk("x_m_wen", {31'b0, bus.m_wen}, 1);
    chk("x_m_ren", {31'b0, bus.m_ren}, 0);
    chk("x_m_addr", bus.m_addr, 32'h8);
    tick(); #1;
    chk("x_idle_rready", {31'b0, bus.m_rdata_ready}, 1);
    chk("x_m_wen_clr", {31'b0, bus.m_wen}, 0);
    chk("x_cnt_d", cnt_d, 2);

    // Load 0x200 with 5-cycle command stall and 3-cycle response backpressure
    bus.d_addr = 32'h200; bus.d_ren = 1; bus.m_req_ready = 0; #1;
    chk("l_d_ready", {31'b0, bus.d_req_ready}, 1);
    tick(); bus.d_ren = 0;
    for (int k = 0; k < 6; k++) begin
      if (k == 5) bus.m_req_ready = 1;
      #1;
      chk("l_stall_addr", bus.m_addr, 32'h200);
      chk("l_stall_ren", {31'b0, bus.m_ren}, 1);
      tick();
    end
    bus.m_rdata = 32'hCAFEF00D; bus.m_rdata_valid = 1; bus.d_rdata_ready = 0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("l_bp_rready", {31'b0, bus.m_rdata_ready}, 0);
      chk("l_bp_dvalid", {31'b0, bus.d_rdata_valid}, 1);
      chk("l_bp_rdata", bus.d_rdata, 32'hCAFEF00D);
      tick();
    end
    bus.d_rdata_ready = 1; #1;
    chk("l_done_rready", {31'b0, bus.m_rdata_ready}, 1);
    chk("l_done_ivalid", {31'b0, bus.i_rdata_valid}, 0);
    tick(); bus.m_rdata_valid = 0; #1;
    chk("l_idle_dvalid", {31'b0, bus.d_rdata_valid}, 0);
    chk("l_cnt_d", cnt_d, 3);
    chk("l_cnt_wait", cnt_wait, 2);

    // Reset during RESP: transaction abandoned, stray beat dropped
    bus.i_addr = 32'h20; bus.i_req_valid = 1; #1;
    chk("r_i_ready", {31'b0, bus.i_req_ready}, 1);
    tick(); bus.i_req_valid = 0; #1;
    chk("r_m_ren", {31'b0, bus.m_ren}, 1);
    tick(); #1;
    chk("r_resp_rready", {31'b0, bus.m_rdata_ready}, 1);
    rst = 0;
    tick(); rst = 1; bus.m_rdata = 32'h0BADF00D; bus.m_rdata_valid = 1; #1;
    chk("r_stray_ivalid", {31'b0, bus.i_rdata_valid}, 0);
    chk("r_stray_dvalid", {31'b0, bus.d_rdata_valid}, 0);
    chk("r_stray_rready", {31'b0, bus.m_rdata_ready}, 1);
    chk("r_cnt_i", cnt_i, 0);
    chk("r_cnt_d", cnt_d, 0);
    chk("r_m_addr", bus.m_addr, 0);
    tick(); bus.m_rdata_valid = 0; #1;
    chk("r_after_ivalid", {31'b0, bus.i_rdata_valid}, 0);
    chk("r_after_ren", {31'b0, bus.m_ren}, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
